// File: rtl/acc_drain_requant.sv
// Drain stage for one systolic PE row: snapshots the accumulators on capture, clears the PEs,
// then streams each column out as a rounded, optionally ReLU'd, saturated int8.
module acc_drain_requant #(
  parameter int N_COLS = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int IDX_W  = $clog2(N_COLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_COLS*ACC_W-1:0] acc_in,
  input  logic                    capture,
  input  logic [4:0]              shift,
  input  logic                    relu_en,
  output logic                    pe_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {StIdle, StDrain} state_e;

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_COLS - 1);
  localparam logic signed [ACC_W:0] SatHi = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SatLo = ~SatHi;
  localparam logic [OUT_W-1:0] OutMax = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OutMin = {1'b1, {(OUT_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic [N_COLS*ACC_W-1:0]   shadow_q, shadow_d;
  logic [4:0]                shift_q, shift_d;
  logic                      relu_q, relu_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      pe_clr_q, pe_clr_d;
  logic                      overrun_q, overrun_d;

  logic                      xfer, last_xfer, accept;
  logic signed [ACC_W-1:0]   sel_acc;
  logic signed [ACC_W:0]     acc_ext, rnd, rounded, shifted;
  logic [OUT_W-1:0]          rq_val;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // A capture is only taken when idle or on the final beat's handshake.
  always_comb begin
    xfer      = out_valid && out_ready;
    last_xfer = xfer && out_last;
    accept    = capture && ((state_q == StIdle) || last_xfer);
    state_d   = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StDrain;
      StDrain: if (last_xfer) state_d = capture ? StDrain : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shadow_d  = shadow_q;
    shift_d   = shift_q;
    relu_d    = relu_q;
    idx_d     = idx_q;
    pe_clr_d  = accept;
    overrun_d = overrun_q || (capture && !accept);
    if (accept) begin
      shadow_d = acc_in;
      shift_d  = shift;
      relu_d   = relu_en;
      idx_d    = '0;
    end else if (xfer) begin
      idx_d = last_xfer ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q  <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      idx_q     <= '0;
      pe_clr_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      shift_q   <= shift_d;
      relu_q    <= relu_d;
      idx_q     <= idx_d;
      pe_clr_q  <= pe_clr_d;
      overrun_q <= overrun_d;
    end
  end

  // One extra bit of headroom so the half-LSB rounding add cannot wrap.
  always_comb begin
    sel_acc = shadow_q[int'(idx_q)*ACC_W +: ACC_W];
    acc_ext = {sel_acc[ACC_W-1], sel_acc};
    rnd     = '0;
    if (shift_q != 5'd0) rnd = (ACC_W+1)'(1) << (shift_q - 5'd1);
    rounded = acc_ext + rnd;
    shifted = rounded >>> shift_q;
    if (relu_q && shifted < 0) rq_val = '0;
    else if (shifted > SatHi)  rq_val = OutMax;
    else if (shifted < SatLo)  rq_val = OutMin;
    else                       rq_val = shifted[OUT_W-1:0];
  end

  always_comb begin
    busy      = (state_q == StDrain);
    out_valid = busy;
    out_idx   = idx_q;
    out_last  = busy && (idx_q == LastIdx);
    out_data  = busy ? rq_val : '0;
    pe_clr    = pe_clr_q;
    overrun   = overrun_q;
  end

endmodule

// File: doc/acc_drain_requant.md
Name: acc_drain_requant

Overview:
- Downstream stage of one systolic PE row: snapshots the row's N_COLS 32-bit accumulators on a capture pulse, then pulses the PEs' accumulator clear.
- Streams the snapshot out one column per handshake, requantizing each value to int8 (rounding shift, optional ReLU, saturation).
- Frees the PE row to start the next tile while the previous tile drains to the output buffer.

Parameters:
- N_COLS, 8, number of PE accumulators in the row (≥2).
- ACC_W, 32, accumulator width (signed).
- OUT_W, 8, output width (signed, saturating).
- IDX_W, $clog2(N_COLS), column index width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- acc_in  in  N_COLS*ACC_W  flattened signed accumulators; column c at bits [c*ACC_W +: ACC_W].
- capture  in  1  one-cycle request to snapshot acc_in.
- shift  in  5  right-shift amount, 0..31; sampled at capture.
- relu_en  in  1  clamp negatives to 0; sampled at capture.
- pe_clr  out  1  accumulator clear to PE row, one-cycle pulse.
- out_valid  out  1  output data valid.
- out_ready  in  1  consumer ready.
- out_data  out  OUT_W  requantized signed value.
- out_idx  out  IDX_W  column index of out_data.
- out_last  out  1  high with the column N_COLS-1 beat.
- busy  out  1  high while in DRAIN.
- overrun  out  1  sticky; set when a capture is dropped.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - state=IDLE; all shadow regs=0, idx=0.
  - pe_clr=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, overrun=0.
  - Reset mid-DRAIN abandons the remaining beats; no pe_clr is issued.
- FSM states: IDLE, DRAIN.
  - IDLE, capture=1: latch all acc_in columns, shift and relu_en into shadow; idx←0; go DRAIN. pe_clr=1 in the following cycle only.
  - DRAIN: out_valid=1, out_idx=idx, out_data=rq(shadow[idx]), out_last=(idx==N_COLS-1).
  - A beat transfers on out_valid&&out_ready. Non-last beat: idx←idx+1. Last beat: go IDLE, idx←0.
  - Last beat with capture=1 in the same cycle: capture is accepted (back-to-back tile). Latch new shadow, stay DRAIN, idx←0, pe_clr pulses next cycle. out_valid stays high with no bubble.
  - capture in DRAIN other than on the last-beat handshake: ignored; shadow unchanged; overrun←1 (sticky until reset).
- Latency:
  - capture at edge t → out_valid=1 and pe_clr=1 during cycle t+1.
  - Beat k is presented no earlier than t+1+k.
- Stall: while out_valid&&!out_ready, out_data/out_idx/out_last are held stable. out_valid never drops before the handshake.
- busy = (state==DRAIN).
- rq(x) requantization, fully combinational from shadow regs (no added latency):
  - s=0: y=x.
  - s>0: y=(x + 2^(s-1)) >>> s, computed in ACC_W+1 bits so the rounding add cannot overflow. Arithmetic shift; round-half-up toward +inf.
  - If relu_en and y<0: y=0.
  - Saturate: y>127→127, y<-128→-128; out_data=y[OUT_W-1:0].
- Any acc_in change after capture has no effect on the beats of that capture.

Test Plan:
- Basic drain: acc_in=[0,1,-1,100,127,128,-128,-129], shift=0, relu_en=0, capture, out_ready=1 → pe_clr pulse at t+1; 8 beats on t+1..t+8 with out_data=[0,1,-1,100,127,127,-128,-128], out_idx 0..7, out_last only on beat 7; busy falls after it.
- Rounding/ReLU: acc_in col0..3=[6,5,-5,-6], shift=2, relu_en=1 → out_data=[2,1,0,0]. Same with relu_en=0 → [2,1,-1,-1]. acc=0x7FFFFFFF, shift=31 → 1 (no wrap).
- Backpressure: out_ready=0 for 5 cycles at beat 3, then 1 → out_valid held, out_data/out_idx=3 stable throughout; total beats still 8, no duplicates or skips.
- Back-to-back and overrun: second capture on the last-beat handshake → next cycle beat idx=0 of new data, second pe_clr pulse, overrun=0. Capture at beat 2 → ignored, overrun=1 and stays 1, drain data unchanged.
- Reset mid-drain: rst=1 at beat 4 → next cycle out_valid=0, busy=0, overrun=0, out_idx=0. A following capture drains cleanly from idx 0.
- Snapshot isolation: change acc_in every cycle after capture → outputs match the captured values only.
